// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset sequencer: FSM states, reset-cause bit
// positions and the counter-width helper.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } seq_state_e;

    localparam int CAUSE_W    = 3;
    localparam int CAUSE_LOCK = 0;
    localparam int CAUSE_BTN  = 1;
    localparam int CAUSE_SOFT = 2;

    // Power-on is logged as a lock-class cause.
    localparam logic [CAUSE_W-1:0] CAUSE_RST_VAL = 3'b001;

    // Width of a counter that must hold 0 .. n-1 (never narrower than one bit).
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Single-bit multi-flop synchroniser with an asynchronous, active-high reset
// that loads a chosen idle value into every stage.
module sync_bit #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= {STAGES{RST_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: merges lock loss, debounced pushbutton and MCU soft requests into one
// reset event, then releases N_CH active-low domains in index order with a fixed stagger.
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int N_CH        = 3,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYC     = 1024,
    parameter int HOLD_CYC    = 32,
    parameter int STAGGER_CYC = 16
) (
    input  logic               hclk,
    input  logic               sys_rst,
    input  logic               pll_locked,
    input  logic               btn_rst_n,
    input  logic               soft_rst_req,
    input  logic               rst_cause_clr,
    output logic [N_CH-1:0]    rst_n_out,
    output logic               sys_ready,
    output logic [CAUSE_W-1:0] rst_cause
);

    localparam int DEB_W  = cnt_w(DEB_CYC);
    localparam int HOLD_W = cnt_w(HOLD_CYC);
    localparam int STG_W  = cnt_w(STAGGER_CYC);
    localparam int IDX_W  = cnt_w(N_CH + 1);

    logic               lock_s, btn_s;
    logic               lock_prev, btn_deb, btn_deb_prev;
    logic [DEB_W-1:0]   deb_cnt;
    logic [CAUSE_W-1:0] cause_set;
    logic               trigger;

    seq_state_e         state_q, state_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [STG_W-1:0]   stg_q, stg_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [N_CH-1:0]    rst_n_q, rst_n_d;
    logic               ready_q, ready_d;
    logic [CAUSE_W-1:0] cause_q, cause_d;

    sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_lock (
        .clk (hclk),
        .rst (sys_rst),
        .d   (pll_locked),
        .q   (lock_s)
    );

    sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_btn (
        .clk (hclk),
        .rst (sys_rst),
        .d   (btn_rst_n),
        .q   (btn_s)
    );

    // Debounce: btn_deb follows btn_s only after DEB_CYC consecutive differing cycles.
    always_ff @(posedge hclk or posedge sys_rst) begin
        if (sys_rst) begin
            lock_prev    <= 1'b0;
            btn_deb      <= 1'b1;
            btn_deb_prev <= 1'b1;
            deb_cnt      <= '0;
        end else begin
            lock_prev    <= lock_s;
            btn_deb_prev <= btn_deb;
            if (btn_s == btn_deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_W'(DEB_CYC - 1)) begin
                btn_deb <= btn_s;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end
    end

    always_comb begin
        cause_set             = '0;
        cause_set[CAUSE_LOCK] = lock_prev & ~lock_s;
        cause_set[CAUSE_BTN]  = btn_deb_prev & ~btn_deb;
        cause_set[CAUSE_SOFT] = soft_rst_req;
    end

    assign trigger = |cause_set;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d = state_q;
        hold_d  = hold_q;
        stg_d   = stg_q;
        idx_d   = idx_q;
        rst_n_d = rst_n_q;
        ready_d = ready_q;
        cause_d = rst_cause_clr ? cause_set : (cause_q | cause_set);

        if (trigger) begin
            state_d = HOLD;
            hold_d  = '0;
            stg_d   = '0;
            idx_d   = '0;
            rst_n_d = '0;
            ready_d = 1'b0;
        end else begin
            case (state_q)
                HOLD: begin
                    if (!(lock_s && btn_deb)) begin
                        hold_d = '0;
                    end else if (hold_q == HOLD_W'(HOLD_CYC - 1)) begin
                        hold_d     = '0;
                        stg_d      = '0;
                        idx_d      = IDX_W'(1);
                        rst_n_d[0] = 1'b1;
                        if (N_CH == 1) begin
                            state_d = RUN;
                            ready_d = 1'b1;
                        end else begin
                            state_d = RELEASE;
                        end
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
                RELEASE: begin
                    if (stg_q == STG_W'(STAGGER_CYC - 1)) begin
                        // Release bits only accumulate; a reset event clears them all at once.
                        stg_d   = '0;
                        rst_n_d = rst_n_q | (N_CH'(1) << idx_q);
                        idx_d   = idx_q + IDX_W'(1);
                        if (idx_q == IDX_W'(N_CH - 1)) begin
                            state_d = RUN;
                            ready_d = 1'b1;
                        end
                    end else begin
                        stg_d = stg_q + STG_W'(1);
                    end
                end
                RUN: begin
                end
                default: begin
                    state_d = HOLD;
                    rst_n_d = '0;
                    ready_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge hclk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= HOLD;
            hold_q  <= '0;
            stg_q   <= '0;
            idx_q   <= '0;
            rst_n_q <= '0;
            ready_q <= 1'b0;
            cause_q <= CAUSE_RST_VAL;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            stg_q   <= stg_d;
            idx_q   <= idx_d;
            rst_n_q <= rst_n_d;
            ready_q <= ready_d;
            cause_q <= cause_d;
        end
    end

    assign rst_n_out = rst_n_q;
    assign sys_ready = ready_q;
    assign rst_cause = cause_q;

endmodule
